// File: rtl/unified_mem_arbiter.sv
// Purpose : shares one single-ported, variable-latency memory between the
//           instruction-fetch port and the data port. Data has fixed priority.
//           Each access runs IDLE -> BUSY_x -> DONE_x and ends in a one-cycle x_ready_o pulse.
// Latency : request seen in IDLE at cycle 0, mem_req_o in cycles 1..1+W,
//           ready at 2+W, next arbitration at 3+W. W is the memory wait.
// Backpr. : a requester holds its request until its ready pulse. A request
//           dropped before it is granted is lost. Memory is held off with mem_req_o/mem_ack_i.
//
// Ports:
//   clk_i, rst_ni                       clock, async active-low reset
//   if_req_i, if_addr_i                 fetch request and byte address
//   if_rdata_o, if_ready_o              fetched word and completion pulse
//   d_req_i, d_we_i, d_addr_i,          data request: store/load, address,
//   d_wdata_i, d_byte_sel_i             store data, size code (passed through)
//   d_rdata_o, d_ready_o                load data and completion pulse
//   mem_req_o, mem_we_o, mem_addr_o,    registered request to memory
//   mem_wdata_o, mem_byte_sel_o
//   mem_rdata_i, mem_ack_i              memory read data and completion
//   bus_err_o                           sticky timeout flag
//
// Build option: define ARB_TIMEOUT_EN to abort an access that has waited
// TIMEOUT_CYCLES busy cycles without mem_ack_i. Undefined, the arbiter
// waits indefinitely and bus_err_o is tied to 0.

module unified_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ready_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [1:0]  d_byte_sel_i,
    output logic [31:0] d_rdata_o,
    output logic        d_ready_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [1:0]  mem_byte_sel_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        bus_err_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_D = 3'd1,
        BUSY_I = 3'd2,
        DONE_D = 3'd3,
        DONE_I = 3'd4
    } state_e;

    state_e      state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [1:0]  mem_byte_sel_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        if_ready_q;
    logic        d_ready_q;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt_q;
    logic       bus_err_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 32'h0;
            mem_wdata_q    <= 32'h0;
            mem_byte_sel_q <= 2'b00;
            if_rdata_q     <= 32'h0;
            d_rdata_q      <= 32'h0;
            if_ready_q     <= 1'b0;
            d_ready_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q      <= 8'd0;
            bus_err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef ARB_TIMEOUT_EN
                    // Cleared every idle cycle, so it is zero on entry to BUSY.
                    tmo_cnt_q <= 8'd0;
`endif
                    if (d_req_i) begin
                        mem_req_q      <= 1'b1;
                        mem_we_q       <= d_we_i;
                        mem_addr_q     <= d_addr_i;
                        mem_wdata_q    <= d_wdata_i;
                        mem_byte_sel_q <= d_byte_sel_i;
                        state_q        <= BUSY_D;
                    end else if (if_req_i) begin
                        mem_req_q      <= 1'b1;
                        mem_we_q       <= 1'b0;
                        mem_addr_q     <= if_addr_i;
                        mem_wdata_q    <= 32'h0;
                        mem_byte_sel_q <= 2'b00;
                        state_q        <= BUSY_I;
                    end
                end

                BUSY_D, BUSY_I: begin
                    // An ack always wins, even in the cycle the timeout would fire.
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        if (state_q == BUSY_D) begin
                            // Stores leave the load-data register untouched.
                            if (!mem_we_q) begin
                                d_rdata_q <= mem_rdata_i;
                            end
                            d_ready_q <= 1'b1;
                            state_q   <= DONE_D;
                        end else begin
                            if_rdata_q <= mem_rdata_i;
                            if_ready_q <= 1'b1;
                            state_q    <= DONE_I;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LAST) begin
                        // Abandon the access and hand back an all-ones word.
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        if (state_q == BUSY_D) begin
                            d_rdata_q <= 32'hFFFF_FFFF;
                            d_ready_q <= 1'b1;
                            state_q   <= DONE_D;
                        end else begin
                            if_rdata_q <= 32'hFFFF_FFFF;
                            if_ready_q <= 1'b1;
                            state_q    <= DONE_I;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
`endif
                end

                DONE_D: begin
                    d_ready_q <= 1'b0;
                    state_q   <= IDLE;
                end

                DONE_I: begin
                    if_ready_q <= 1'b0;
                    state_q    <= IDLE;
                end

                default: begin
                    mem_req_q  <= 1'b0;
                    if_ready_q <= 1'b0;
                    d_ready_q  <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_o      = mem_req_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign mem_byte_sel_o = mem_byte_sel_q;
    assign if_rdata_o     = if_rdata_q;
    assign d_rdata_o      = d_rdata_q;
    assign if_ready_o     = if_ready_q;
    assign d_ready_o      = d_ready_q;

`ifdef ARB_TIMEOUT_EN
    assign bus_err_o = bus_err_q;
`else
    // No timeout hardware in this build; the parameter is intentionally unused.
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = |TIMEOUT_CYCLES;
    assign bus_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Purpose : self-checking bench for unified_mem_arbiter.
// Latency : checks ready at cycle 2+W and re-arbitration at 3+W.
// Backpr. : the memory model acks after a programmable wait.

module tb_unified_mem_arbiter;

    logic        clk_i;
    logic        rst_ni;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ready_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [1:0]  d_byte_sel_i;
    logic [31:0] d_rdata_o;
    logic        d_ready_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [1:0]  mem_byte_sel_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        bus_err_o;

    unified_mem_arbiter #(.TIMEOUT_CYCLES(15)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .if_req_i       (if_req_i),
        .if_addr_i      (if_addr_i),
        .if_rdata_o     (if_rdata_o),
        .if_ready_o     (if_ready_o),
        .d_req_i        (d_req_i),
        .d_we_i         (d_we_i),
        .d_addr_i       (d_addr_i),
        .d_wdata_i      (d_wdata_i),
        .d_byte_sel_i   (d_byte_sel_i),
        .d_rdata_o      (d_rdata_o),
        .d_ready_o      (d_ready_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_byte_sel_o (mem_byte_sel_o),
        .mem_rdata_i    (mem_rdata_i),
        .mem_ack_i      (mem_ack_i),
        .bus_err_o      (bus_err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: acks after mem_wait busy cycles with the stored word.
    logic [31:0] memimg [logic [31:0]];
    int          mem_wait     = 0;
    bit          never_ack    = 1'b0;
    bit          spurious_ack = 1'b0;

    initial begin
        int wcnt;
        wcnt        = 0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h5555_AAAA;
        forever begin
            @(posedge clk_i);
            #1;
            if (mem_req_o && !mem_ack_i && !never_ack) begin
                if (wcnt == mem_wait) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = memimg.exists(mem_addr_o) ? memimg[mem_addr_o] : 32'h0;
                end else begin
                    wcnt++;
                end
            end else begin
                mem_ack_i   = spurious_ack;
                mem_rdata_i = 32'h5555_AAAA;
                wcnt        = 0;
            end
        end
    end

    typedef struct packed {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  bsel;
        logic [3:0]  w;
        logic [31:0] mdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic check_reset_vals(input string tag);
        chk({tag, "_mem_req"},  {31'h0, mem_req_o}, 32'h0);
        chk({tag, "_mem_we"},   {31'h0, mem_we_o}, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr_o, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
        chk({tag, "_mem_bsel"}, {30'h0, mem_byte_sel_o}, 32'h0);
        chk({tag, "_if_rdata"}, if_rdata_o, 32'h0);
        chk({tag, "_d_rdata"},  d_rdata_o, 32'h0);
        chk({tag, "_readys"},   {30'h0, if_ready_o, d_ready_o}, 32'h0);
        chk({tag, "_bus_err"},  {31'h0, bus_err_o}, 32'h0);
    endtask

    // One isolated access: grant, field, latency, pulse-width and data checks.
    task automatic run_vec(input vec_t v, input string tag);
        int          rdy_cyc;
        int          pulses;
        int          wrong;
        logic [31:0] got;
        @(posedge clk_i);
        #1;
        memimg[v.addr] = v.mdata;
        mem_wait       = int'(v.w);
        if (v.is_d) begin
            d_req_i      = 1'b1;
            d_we_i       = v.we;
            d_addr_i     = v.addr;
            d_wdata_i    = v.wdata;
            d_byte_sel_i = v.bsel;
        end else begin
            if_req_i  = 1'b1;
            if_addr_i = v.addr;
        end
        @(negedge clk_i);
        rdy_cyc = -1;
        pulses  = 0;
        wrong   = 0;
        got     = 32'h0;
        for (int c = 1; c <= int'(v.w) + 3; c++) begin
            @(negedge clk_i);
            if (c == 1) begin
                chk({tag, "_mem_req"},   {31'h0, mem_req_o}, 32'h1);
                chk({tag, "_mem_addr"},  mem_addr_o, v.addr);
                chk({tag, "_mem_we"},    {31'h0, mem_we_o}, {31'h0, v.is_d & v.we});
                chk({tag, "_mem_wdata"}, mem_wdata_o, v.is_d ? v.wdata : 32'h0);
                chk({tag, "_mem_bsel"},  {30'h0, mem_byte_sel_o}, v.is_d ? {30'h0, v.bsel} : 32'h0);
            end
            if (v.is_d ? d_ready_o : if_ready_o) begin
                pulses++;
                if (rdy_cyc < 0) begin
                    rdy_cyc = c;
                    got     = v.is_d ? d_rdata_o : if_rdata_o;
                end
                d_req_i  = 1'b0;
                if_req_i = 1'b0;
            end
            if (v.is_d ? if_ready_o : d_ready_o) wrong++;
        end
        d_req_i  = 1'b0;
        if_req_i = 1'b0;
        chk({tag, "_ready_cycle"}, 32'(rdy_cyc), 32'(int'(v.w) + 2));
        chk({tag, "_pulses"},      32'(pulses), 32'd1);
        chk({tag, "_rdata"},       got, v.exp_rdata);
        chk({tag, "_other_ready"}, 32'(wrong), 32'd0);
        chk({tag, "_req_idle"},    {31'h0, mem_req_o}, 32'h0);
    endtask

    int ws    [10] = '{0, 3, 1, 5, 2, 0, 4, 1, 0, 2};
    logic [31:0] bdata [10] = '{32'h1000_0000, 32'h1000_0111, 32'h1000_0222, 32'h1000_0333,
                                32'h1000_0444, 32'h1000_0555, 32'h1000_0666, 32'h1000_0777,
                                32'h1000_0888, 32'h1000_0999};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d_cyc, i_cyc, both, pulses, k, exp_cyc, dbl, last_req;
        bit          prev_rdy;
        logic [31:0] d_got, i_got, d_keep, i_keep;

        vecs[0] = '{is_d:1'b0, we:1'b0, addr:32'h100, wdata:32'h0,         bsel:2'b00, w:4'd0, mdata:32'h2001_0005, exp_rdata:32'h2001_0005};
        vecs[1] = '{is_d:1'b1, we:1'b0, addr:32'h400, wdata:32'h0,         bsel:2'b11, w:4'd2, mdata:32'h1122_3344, exp_rdata:32'h1122_3344};
        vecs[2] = '{is_d:1'b1, we:1'b1, addr:32'h008, wdata:32'hDEAD_BEEF, bsel:2'b10, w:4'd1, mdata:32'hCAFE_F00D, exp_rdata:32'h1122_3344};
        vecs[3] = '{is_d:1'b0, we:1'b0, addr:32'h104, wdata:32'h0,         bsel:2'b00, w:4'd5, mdata:32'h00A0_0093, exp_rdata:32'h00A0_0093};
        vecs[4] = '{is_d:1'b1, we:1'b0, addr:32'h7FC, wdata:32'h0,         bsel:2'b01, w:4'd0, mdata:32'hFFFF_0000, exp_rdata:32'hFFFF_0000};
        vecs[5] = '{is_d:1'b1, we:1'b1, addr:32'h010, wdata:32'h0000_0001, bsel:2'b00, w:4'd3, mdata:32'h7777_7777, exp_rdata:32'hFFFF_0000};

        rst_ni       = 1'b0;
        if_req_i     = 1'b0;
        if_addr_i    = 32'h0;
        d_req_i      = 1'b0;
        d_we_i       = 1'b0;
        d_addr_i     = 32'h0;
        d_wdata_i    = 32'h0;
        d_byte_sel_i = 2'b00;

        @(negedge clk_i);
        check_reset_vals("reset");
        rst_ni = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Both ports request in the same cycle: data first, fetch afterwards.
        @(posedge clk_i);
        #1;
        memimg[32'h400] = 32'h0BAD_F00D;
        memimg[32'h104] = 32'h1234_5678;
        mem_wait        = 2;
        d_req_i         = 1'b1;
        d_we_i          = 1'b0;
        d_addr_i        = 32'h400;
        d_byte_sel_i    = 2'b11;
        if_req_i        = 1'b1;
        if_addr_i       = 32'h104;
        @(negedge clk_i);
        d_cyc = -1; i_cyc = -1; both = 0; d_got = 32'h0; i_got = 32'h0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk_i);
            if (c == 1) chk("coll_first_addr", mem_addr_o, 32'h400);
            if (c == 6) chk("coll_fetch_addr", mem_addr_o, 32'h104);
            if (d_ready_o && if_ready_o) both++;
            if (d_ready_o) begin
                if (d_cyc < 0) begin d_cyc = c; d_got = d_rdata_o; end
                d_req_i = 1'b0;
            end
            if (if_ready_o) begin
                if (i_cyc < 0) begin i_cyc = c; i_got = if_rdata_o; end
                if_req_i = 1'b0;
            end
        end
        chk("coll_d_ready_cycle",  32'(d_cyc), 32'd4);
        chk("coll_if_ready_cycle", 32'(i_cyc), 32'd9);
        chk("coll_d_rdata",        d_got, 32'h0BAD_F00D);
        chk("coll_if_rdata",       i_got, 32'h1234_5678);
        chk("coll_both_ready",     32'(both), 32'd0);

        // Stray acks while idle must not complete anything.
        d_keep = d_rdata_o;
        i_keep = if_rdata_o;
        @(posedge clk_i);
        #1;
        spurious_ack = 1'b1;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (d_ready_o || if_ready_o) pulses++;
        end
        spurious_ack = 1'b0;
        @(negedge clk_i);
        chk("spur_pulses",   32'(pulses), 32'd0);
        chk("spur_d_rdata",  d_rdata_o, d_keep);
        chk("spur_if_rdata", if_rdata_o, i_keep);
        chk("spur_mem_req",  {31'h0, mem_req_o}, 32'h0);

        // Ten back-to-back fetches, request held, address advanced on ready.
        @(posedge clk_i);
        #1;
        for (int j = 0; j < 10; j++) memimg[32'h200 + 32'(4 * j)] = bdata[j];
        mem_wait  = ws[0];
        if_req_i  = 1'b1;
        if_addr_i = 32'h200;
        @(negedge clk_i);
        k = 0; exp_cyc = 2 + ws[0]; dbl = 0; prev_rdy = 1'b0;
        for (int c = 1; c <= 150 && k < 10; c++) begin
            @(negedge clk_i);
            if (if_ready_o) begin
                if (prev_rdy) dbl++;
                chk($sformatf("b2b%0d_cycle", k), 32'(c), 32'(exp_cyc));
                chk($sformatf("b2b%0d_data", k), if_rdata_o, bdata[k]);
                k++;
                if (k < 10) begin
                    if_addr_i = 32'h200 + 32'(4 * k);
                    mem_wait  = ws[k];
                    exp_cyc   = c + 3 + ws[k];
                end else begin
                    if_req_i = 1'b0;
                end
            end
            prev_rdy = if_ready_o;
        end
        if_req_i = 1'b0;
        chk("b2b_count",  32'(k), 32'd10);
        chk("b2b_double", 32'(dbl), 32'd0);

        // Reset asserted while a load is waiting on memory.
        @(posedge clk_i);
        #1;
        memimg[32'h30] = 32'h3030_3030;
        mem_wait       = 10;
        d_req_i        = 1'b1;
        d_we_i         = 1'b0;
        d_addr_i       = 32'h30;
        d_byte_sel_i   = 2'b01;
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rstb_busy_req", {31'h0, mem_req_o}, 32'h1);
        rst_ni = 1'b0;
        #1;
        check_reset_vals("rstb");
        d_req_i = 1'b0;
        pulses  = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            if (d_ready_o || if_ready_o || mem_req_o) pulses++;
        end
        rst_ni = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (d_ready_o || if_ready_o || mem_req_o) pulses++;
        end
        chk("rstb_no_activity", 32'(pulses), 32'd0);
        run_vec(vecs[0], "after_rst");

`ifdef ARB_TIMEOUT_EN
        // Memory never answers: abort after 15 busy cycles.
        @(posedge clk_i);
        #1;
        never_ack    = 1'b1;
        d_req_i      = 1'b1;
        d_we_i       = 1'b0;
        d_addr_i     = 32'h44;
        d_byte_sel_i = 2'b00;
        @(negedge clk_i);
        d_cyc = -1; last_req = -1; d_got = 32'h0;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk_i);
            if (mem_req_o) last_req = c;
            if (d_ready_o) begin
                if (d_cyc < 0) begin d_cyc = c; d_got = d_rdata_o; end
                d_req_i = 1'b0;
            end
        end
        d_req_i   = 1'b0;
        never_ack = 1'b0;
        chk("tmo_last_req",    32'(last_req), 32'd15);
        chk("tmo_ready_cycle", 32'(d_cyc), 32'd16);
        chk("tmo_rdata",       d_got, 32'hFFFF_FFFF);
        chk("tmo_bus_err",     {31'h0, bus_err_o}, 32'h1);
        run_vec(vecs[0], "tmo_after");
        chk("tmo_bus_err_sticky", {31'h0, bus_err_o}, 32'h1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("tmo_bus_err_reset", {31'h0, bus_err_o}, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
`else
        chk("bus_err_tied", {31'h0, bus_err_o}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port and its data-memory port. Each port is arbitrated, then sequenced through a req/ack handshake to the memory, and answered with a one-cycle ready pulse. While a port's ready is low, the pipeline stalls that stage (IF: hold PC and IF/ID; MEM: freeze the whole pipeline). Data accesses have fixed priority over instruction fetch.

## Interface
- TIMEOUT_CYCLES, 15: cycles a granted access may wait for mem_ack before abort. Used only with ARB_TIMEOUT_EN.
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- if_req  in  1  fetch request; held with if_addr until if_ready.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched word; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for the fetch port.
- d_req  in  1  data request; held with all d_* fields until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_byte_sel  in  2  access size code, passed to memory unchanged.
- d_rdata  out  32  load data; valid while d_ready=1.
- d_ready  out  1  one-cycle completion pulse for the data port.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we, mem_addr[32], mem_wdata[32], mem_byte_sel[2]  out  registered copies of the granted request.
- mem_rdata  in  32  memory read data; valid when mem_ack=1.
- mem_ack  in  1  memory completion; may be high in the first mem_req cycle.
- bus_err  out  1  sticky timeout flag.

## Operation
- States: IDLE, BUSY_D, BUSY_I, DONE_D, DONE_I.
- IDLE:
  - d_req=1 → latch d_* into mem_* registers, set mem_req, go to BUSY_D.
  - else if_req=1 → latch if_addr, mem_we=0, mem_wdata=0, mem_byte_sel=0, go to BUSY_I.
  - Both requests high → data wins; the fetch waits.
- BUSY_x:
  - mem_req=1 and mem_* fields stable.
  - On mem_ack=1: capture mem_rdata into x_rdata (loads and fetches only), clear mem_req, go to DONE_x.
- DONE_x:
  - x_ready=1 for exactly this cycle, then go to IDLE.
  - Requests are not sampled in DONE_x. The requester may drop or change its request at the edge ending DONE_x.
- Stores: d_rdata keeps its previous value. d_ready still pulses.
- Requests are sampled only in IDLE. A request that deasserts before it is granted is silently dropped.
- The two ready outputs are never high in the same cycle.

## Timing
- Reset values: state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_byte_sel=0; if_rdata=0, d_rdata=0; if_ready=0, d_ready=0; bus_err=0.
- Reset asserted mid-access: immediately returns to IDLE and drops mem_req, with no ready pulse. The memory must tolerate an abandoned request.
- Latency with memory wait of W cycles (W=0 means ack in the first mem_req cycle):
  - Request seen in IDLE at cycle 0.
  - mem_req high in cycles 1..1+W.
  - ready at cycle 2+W.
  - Next arbitration at cycle 3+W.
  - Per-access occupancy: 3+W cycles.
- mem_ack seen while not in BUSY_x is ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A 5-bit-or-wider counter clears on entry to BUSY_x and increments each BUSY cycle with mem_ack=0.
  - When it reaches TIMEOUT_CYCLES with no ack: drop mem_req, go to DONE_x, return x_rdata=32'hFFFF_FFFF, set bus_err.
  - bus_err stays set until reset.
  - An ack arriving in the same cycle the count reaches the limit takes precedence over the timeout.
- ARB_TIMEOUT_EN undefined:
  - BUSY_x waits indefinitely.
  - bus_err is tied to 0 and no counter exists.

## Test plan
- Single fetch, W=0: if_req=1, if_addr=0x100, memory returns 0x20010005 → mem_req in cycle 1, if_ready and if_rdata=0x20010005 in cycle 2, mem_addr=0x100.
- Collision: d_req (load 0x400) and if_req (0x104) raised in the same cycle, W=2 → data served first with d_ready at cycle 4; fetch granted at IDLE cycle 5, if_ready at cycle 9.
- Store: d_we=1, d_addr=0x8, d_wdata=0xDEADBEEF, d_byte_sel=2'b10 → mem_we=1 with those exact fields; d_ready pulses; d_rdata unchanged.
- Back-to-back fetches, 10 addresses, random W in 0..5 → one if_ready per request, in order, with matching data; ready never high two cycles in a row.
- Reset low during BUSY_D → mem_req=0 immediately, no ready pulse, all outputs at reset values; after release, an IDLE request proceeds normally.
- With ARB_TIMEOUT_EN: memory never acks → at BUSY cycle 15, mem_req drops, x_ready pulses with rdata=0xFFFFFFFF, and bus_err=1 until reset.
